// File: rtl/bin2bcd_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_seq_if
//  Description : Start/operand and result bundle for the sequential
//                binary-to-BCD converter. The master side drives the start
//                request and operand. The slave side (the converter) returns
//                the packed BCD digits, status and blanking flags.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bin2bcd_seq_if #(
    parameter int BIN_W  = 6,
    parameter int DIGITS = 2
);
    logic                  init;
    logic [BIN_W-1:0]      bin;
    logic [4*DIGITS-1:0]   bcd;
    logic                  busy;
    logic                  done;
    logic [DIGITS-1:0]     blank;

    // Requester side: the upstream multiplier or a testbench.
    modport master (
        output init,
        output bin,
        input  bcd,
        input  busy,
        input  done,
        input  blank
    );

    // Converter side.
    modport slave (
        input  init,
        input  bin,
        output bcd,
        output busy,
        output done,
        output blank
    );
endinterface
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_seq
//  Description : Iterative double-dabble (shift-and-add-3) binary-to-BCD
//                converter. Each input bit takes one adjust cycle and one
//                shift cycle. The result and a one-cycle done pulse appear on
//                the final shift edge.
//                Optional leading-zero blanking is enabled by defining the
//                macro BIN2BCD_LZB_EN. Without that macro the blank flags are
//                tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq #(
    parameter int BIN_W  = 6,
    parameter int DIGITS = 2
) (
    input  wire logic      clk,
    input  wire logic      rst,
    bin2bcd_seq_if.slave   bus
);

    localparam int c_SH_W  = 4 * DIGITS + BIN_W;
    localparam int c_CNT_W = $clog2(BIN_W + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(BIN_W);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADJ   = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                 r_state;
    logic [c_SH_W-1:0]      r_sh;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [4*DIGITS-1:0]    r_bcd;
    logic                   r_busy;
    logic                   r_done;

    logic [c_SH_W-1:0]      w_sh_adj;
    logic [c_SH_W-1:0]      w_sh_next;
    logic [4*DIGITS-1:0]    w_bcd_next;

    // The binary part passes through the adjust step untouched.
    assign w_sh_adj[BIN_W-1:0] = r_sh[BIN_W-1:0];

    // Each scratch BCD nibble is corrected independently. A nibble of 5..9
    // becomes 8..12, so the following shift carries into the next digit.
    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        logic [3:0] w_nib;
        assign w_nib = r_sh[BIN_W + 4*i +: 4];
        assign w_sh_adj[BIN_W + 4*i +: 4] = (w_nib >= 4'd5) ? (w_nib + 4'd3) : w_nib;
    end

    // The shift moves the next binary MSB into the BCD units digit.
    assign w_sh_next  = {r_sh[c_SH_W-2:0], 1'b0};
    assign w_bcd_next = w_sh_next[c_SH_W-1:BIN_W];

`ifdef BIN2BCD_LZB_EN
    logic [DIGITS-1:0] r_blank;
    logic [DIGITS-1:0] w_blank_next;
    logic              w_hz;

    // Scan from the most significant digit downward. A digit blanks only
    // while it and everything above it are zero. The units digit never
    // blanks, so a zero result still shows "0".
    always_comb begin
        w_blank_next = '0;
        w_hz         = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            w_hz            = w_hz & (w_bcd_next[4*i +: 4] == 4'd0);
            w_blank_next[i] = w_hz;
        end
    end

    assign bus.blank = r_blank;
`else
    assign bus.blank = '0;
`endif

    // Conversion FSM. All outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_sh    <= '0;
            r_cnt   <= '0;
            r_bcd   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef BIN2BCD_LZB_EN
            r_blank <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.init) begin
                        r_sh    <= {{(4*DIGITS){1'b0}}, bus.bin};
                        r_cnt   <= c_CNT_INIT;
                        r_busy  <= 1'b1;
                        r_state <= ST_ADJ;
                    end
                end
                ST_ADJ: begin
                    r_sh    <= w_sh_adj;
                    r_state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    r_sh  <= w_sh_next;
                    r_cnt <= r_cnt - c_CNT_ONE;
                    if (r_cnt == c_CNT_ONE) begin
                        r_bcd   <= w_bcd_next;
                        r_done  <= 1'b1;
`ifdef BIN2BCD_LZB_EN
                        r_blank <= w_blank_next;
`endif
                        r_state <= ST_DONE;
                    end else begin
                        r_state <= ST_ADJ;
                    end
                end
                ST_DONE: begin
                    // A start request seen here is dropped on purpose. The
                    // caller must pulse init again once the converter is idle.
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.bcd  = r_bcd;
    assign bus.busy = r_busy;
    assign bus.done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bin2bcd_seq
//  Description : Self-checking bench for bin2bcd_seq. It applies a vector
//                table, sweeps every 6-bit input, and runs hand-written
//                sequences for held init, operand change and abort by reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bin2bcd_seq;

    localparam int c_BIN_W  = 6;
    localparam int c_DIGITS = 2;
    localparam int c_LAT    = 2 * c_BIN_W;

`ifdef BIN2BCD_LZB_EN
    localparam logic [1:0] c_BL_SMALL = 2'b10;
`else
    localparam logic [1:0] c_BL_SMALL = 2'b00;
`endif
    localparam logic [1:0] c_BL_BIG = 2'b00;

    logic clk;
    logic rst;

    int checks;
    int errors;

    bin2bcd_seq_if #(.BIN_W(c_BIN_W), .DIGITS(c_DIGITS)) bus ();

    bin2bcd_seq #(.BIN_W(c_BIN_W), .DIGITS(c_DIGITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] bin;
        logic [7:0] bcd;
        logic [1:0] blank;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Run one conversion. The operand is driven at a negedge and accepted on
    // the next posedge. All DUT outputs are sampled 1 time unit after a
    // posedge.
    task automatic convert(input logic [5:0] v, output logic [7:0] got_bcd,
                           output logic [1:0] got_blank, output int lat);
        logic [7:0] prev_bcd;
        logic       moved;
        prev_bcd = bus.bcd;
        moved    = 1'b0;
        @(negedge clk);
        bus.bin  = v;
        bus.init = 1'b1;
        @(posedge clk);
        #1;
        bus.init = 1'b0;
        check("busy_after_accept", 32'(bus.busy), 32'd1);
        lat = 0;
        while (!bus.done && lat < 40) begin
            if (bus.bcd !== prev_bcd) moved = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        check("done_seen", 32'(bus.done), 32'd1);
        check("bcd_stable_mid_conv", 32'(moved), 32'd0);
        got_bcd   = bus.bcd;
        got_blank = bus.blank;
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(bus.done), 32'd0);
        check("busy_cleared", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        logic [7:0] b;
        logic [1:0] bl;
        int         lat;
        int         ndone;

        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        bus.init = 1'b0;
        bus.bin  = '0;

        vecs[0] = '{6'd42, 8'h42, c_BL_BIG};
        vecs[1] = '{6'd0,  8'h00, c_BL_SMALL};
        vecs[2] = '{6'd9,  8'h09, c_BL_SMALL};
        vecs[3] = '{6'd10, 8'h10, c_BL_BIG};
        vecs[4] = '{6'd63, 8'h63, c_BL_BIG};
        vecs[5] = '{6'd7,  8'h07, c_BL_SMALL};
        vecs[6] = '{6'd17, 8'h17, c_BL_BIG};
        vecs[7] = '{6'd55, 8'h55, c_BL_BIG};
        vecs[8] = '{6'd1,  8'h01, c_BL_SMALL};
        vecs[9] = '{6'd39, 8'h39, c_BL_BIG};

        // Reset for two edges, then stay idle for five cycles.
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("rst_bcd", 32'(bus.bcd), 32'h00);
            check("rst_done", 32'(bus.done), 32'd0);
            check("rst_busy", 32'(bus.busy), 32'd0);
        end
        check("rst_blank", 32'(bus.blank), 32'd0);

        // Directed table, including the latency check.
        for (int i = 0; i < 10; i++) begin
            convert(vecs[i].bin, b, bl, lat);
            check("tbl_bcd", 32'(b), 32'(vecs[i].bcd));
            check("tbl_blank", 32'(bl), 32'(vecs[i].blank));
            check("tbl_latency", 32'(lat), 32'(c_LAT));
        end

        // Full sweep of every input value.
        for (int v = 0; v < 64; v++) begin
            convert(6'(v), b, bl, lat);
            check("sweep_bcd", 32'(b), 32'({4'(v / 10), 4'(v % 10)}));
        end

        // Hold init for the whole conversion and through the DONE cycle. The
        // operand changes right after acceptance.
        @(negedge clk);
        bus.bin  = 6'd17;
        bus.init = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.bin = 6'd5;
        ndone = 0;
        lat   = 0;
        while (ndone == 0 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.done) ndone++;
        end
        check("hold_done_seen", 32'(ndone), 32'd1);
        check("hold_bcd", 32'(bus.bcd), 32'h17);
        // This edge samples init=1 while the DUT is in DONE.
        @(posedge clk);
        #1;
        bus.init = 1'b0;
        check("hold_busy_after_done", 32'(bus.busy), 32'd0);
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) ndone++;
        end
        check("hold_no_restart", 32'(ndone), 32'd1);

        // Abort a conversion with reset at the fifth cycle after acceptance.
        @(negedge clk);
        bus.bin  = 6'd55;
        bus.init = 1'b1;
        @(posedge clk);
        #1;
        bus.init = 1'b0;
        for (int i = 0; i < 4; i++) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_bcd", 32'(bus.bcd), 32'h00);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_blank", 32'(bus.blank), 32'd0);
        ndone = 0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'd0);
        convert(6'd9, b, bl, lat);
        check("after_abort_bcd", 32'(b), 32'h09);
        check("after_abort_blank", 32'(bl), 32'(c_BL_SMALL));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
